// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes, ALU control codes, FSM states and instruction field
// positions for the ALU issue/writeback sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned NREGS      = 8;
    localparam int unsigned SHAMT_W    = 6;
    localparam int unsigned REG_AW     = 3;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned INSTR_W    = 16;

    localparam int unsigned OP_LSB    = 13;
    localparam int unsigned RD_LSB    = 10;
    localparam int unsigned RA_LSB    = 7;
    localparam int unsigned RB_LSB    = 4;
    localparam int unsigned SHAMT_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR = 3'b101;
    localparam logic [OP_W-1:0] OP_CMP = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP = 3'b111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHL1 = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHR1 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_WB
    } state_e;

    // CMP reuses the subtractor so the ALU compare flags settle on A vs B.
    function automatic logic [ALU_CTRL_W-1:0] alu_ctrl_of(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD:  alu_ctrl_of = ALU_ADD;
            OP_SUB:  alu_ctrl_of = ALU_SUB;
            OP_AND:  alu_ctrl_of = ALU_AND;
            OP_OR:   alu_ctrl_of = ALU_OR;
            OP_SHL:  alu_ctrl_of = ALU_SHL1;
            OP_SHR:  alu_ctrl_of = ALU_SHR1;
            OP_CMP:  alu_ctrl_of = ALU_SUB;
            default: alu_ctrl_of = ALU_ADD;
        endcase
    endfunction

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        is_shift = (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic writes_rf(input logic [OP_W-1:0] op);
        writes_rf = (op != OP_CMP) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x DATA_W register file: two async read ports, preload and writeback
// write ports; writeback overrides a same-cycle preload to the same address.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              pl_en,
    input  logic [REG_AW-1:0] pl_addr,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] mem_q [NREGS];

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

    // Writeback is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (pl_en) begin
                mem_q[pl_addr] <= pl_data;
            end
            if (wb_en) begin
                mem_q[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue/writeback sequencer around an external 64-bit ALU; multi-bit shifts
// are built by iterating the ALU's shift-by-1 operations.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  wr_en,
    input  logic [REG_AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_gt,
    input  logic                  alu_lt,
    input  logic                  alu_eq,
    output logic                  done_valid,
    output logic [REG_AW-1:0]     done_rd,
    output logic [DATA_W-1:0]     done_data,
    output logic                  flag_gt,
    output logic                  flag_lt,
    output logic                  flag_eq
);

    state_e                state_q, state_d;
    logic [OP_W-1:0]       op_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [ALU_CTRL_W-1:0] ctrl_d;
    logic                  accept_c;
    logic                  zero_shift_c;
    logic                  wb_en_c;
    logic [DATA_W-1:0]     rd_a_c, rd_b_c;

    logic [OP_W-1:0]    op_in;
    logic [REG_AW-1:0]  rd_in, ra_in, rb_in;
    logic [SHAMT_W-1:0] shamt_in;

    assign op_in    = instr[OP_LSB +: OP_W];
    assign rd_in    = instr[RD_LSB +: REG_AW];
    assign ra_in    = instr[RA_LSB +: REG_AW];
    assign rb_in    = instr[RB_LSB +: REG_AW];
    assign shamt_in = instr[SHAMT_LSB +: SHAMT_W];

    assign zero_shift_c = is_shift(op_in) && (shamt_in == SHAMT_W'(0));
    assign wb_en_c      = (state_q == ST_WB) && writes_rf(op_q);

    alu_seq_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra_in),
        .rb_addr (rb_in),
        .ra_data (rd_a_c),
        .rb_data (rd_b_c),
        .pl_en   (wr_en),
        .pl_addr (wr_addr),
        .pl_data (wr_data),
        .wb_en   (wb_en_c),
        .wb_addr (done_rd),
        .wb_data (done_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the ALU control to present during the following cycle.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ALU_ADD;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept_c = 1'b1;
                    if (zero_shift_c) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = is_shift(op_in) ? ST_SHIFT : ST_EXEC;
                        ctrl_d  = alu_ctrl_of(op_in);
                    end
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_WB;
                end else begin
                    ctrl_d = alu_ctrl;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; alu_a doubles as the shift accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b1;
            done_valid  <= 1'b0;
            done_rd     <= '0;
            done_data   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= ALU_ADD;
            flag_gt     <= 1'b0;
            flag_lt     <= 1'b0;
            flag_eq     <= 1'b0;
            op_q        <= OP_NOP;
            cnt_q       <= '0;
        end else begin
            instr_ready <= (state_d == ST_IDLE);
            done_valid  <= (state_d == ST_WB);
            alu_ctrl    <= ctrl_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q    <= op_in;
                        done_rd <= rd_in;
                        cnt_q   <= shamt_in;
                        if (zero_shift_c) begin
                            done_data <= rd_a_c;
                        end else begin
                            alu_a <= rd_a_c;
                            alu_b <= rd_b_c;
                        end
                    end
                end
                ST_EXEC: begin
                    done_data <= alu_out;
                    if (op_q == OP_CMP) begin
                        flag_gt <= alu_gt;
                        flag_lt <= alu_lt;
                        flag_eq <= alu_eq;
                    end
                end
                ST_SHIFT: begin
                    alu_a     <= alu_out;
                    done_data <= alu_out;
                    cnt_q     <= cnt_q - SHAMT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU stand-in, register and
// flag model, directed scenarios followed by randomized instruction traffic.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [63:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_ctrl;
    logic        alu_gt, alu_lt, alu_eq;
    logic        done_valid;
    logic [2:0]  done_rd;
    logic [63:0] done_data;
    logic        flag_gt, flag_lt, flag_eq;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] SHL = 3'd4, SHR = 3'd5, CMP = 3'd6, NOP = 3'd7;

    int errors = 0;
    int checks = 0;

    logic [63:0] regs_m [8];
    logic        gt_m = 1'b0, lt_m = 1'b0, eq_m = 1'b0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_gt      (alu_gt),
        .alu_lt      (alu_lt),
        .alu_eq      (alu_eq),
        .done_valid  (done_valid),
        .done_rd     (done_rd),
        .done_data   (done_data),
        .flag_gt     (flag_gt),
        .flag_lt     (flag_lt),
        .flag_eq     (flag_eq)
    );

    // Stand-in for the external 64-bit ALU.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a << 1;
            3'b101:  alu_out = alu_a >> 1;
            default: alu_out = '0;
        endcase
    end
    assign alu_gt = (alu_a > alu_b);
    assign alu_lt = (alu_a < alu_b);
    assign alu_eq = (alu_a == alu_b);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [63:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        regs_m[addr] = data;
    endtask

    // Issue one instruction, optionally with a preload of ra at the accept edge
    // (old value must be read) or a preload of rd at the writeback edge.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [5:0] shamt,
                             input bit pl_ra, input bit collide);
        logic [63:0] a, b, res, junk;
        bit          shift, writes;
        int          exp_lat, lat, w;
        shift  = (op == SHL) || (op == SHR);
        writes = (op != CMP) && (op != NOP);
        a = regs_m[ra];
        b = regs_m[rb];
        case (op)
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND_:    res = a & b;
            OR_:     res = a | b;
            SHL:     res = a << shamt;
            SHR:     res = a >> shamt;
            default: res = '0;
        endcase
        exp_lat = shift ? 1 + int'(shamt) : 2;

        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("ready_wait", 64'(instr_ready), 64'd1);
        instr       = shift ? {op, rd, ra, 1'b0, shamt} : {op, rd, ra, rb, 4'b0000};
        instr_valid = 1'b1;
        if (pl_ra) begin
            junk    = {$urandom, $urandom};
            wr_en   = 1'b1;
            wr_addr = ra;
            wr_data = junk;
            regs_m[ra] = junk;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wr_en       = 1'b0;

        lat = 1;
        while (!done_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("done_rd", 64'(done_rd), 64'(rd));
        if (writes) check_eq("done_data", done_data, res);

        if (collide) begin
            junk    = {$urandom, $urandom};
            wr_en   = 1'b1;
            wr_addr = rd;
            wr_data = junk;
            regs_m[rd] = junk;
        end
        if (writes) regs_m[rd] = res;
        if (op == CMP) begin
            gt_m = a > b;
            lt_m = a < b;
            eq_m = a == b;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_eq("done_pulse", 64'(done_valid), 64'd0);
        check_eq("ready_after_wb", 64'(instr_ready), 64'd1);
        check_eq("flags", 64'({flag_gt, flag_lt, flag_eq}), 64'({gt_m, lt_m, eq_m}));
    endtask

    // OR r,r,r leaves the register unchanged and exposes it on done_data.
    task automatic read_reg(input logic [2:0] r);
        run_instr(OR_, r, r, r, 6'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(0, 3));
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int pulses, first_pulse;
        for (int i = 0; i < 8; i++) regs_m[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(instr_ready), 64'd1);
        check_eq("rst_done", 64'({done_valid, done_rd}), 64'd0);
        check_eq("rst_done_data", done_data, 64'd0);
        check_eq("rst_alu_a", alu_a, 64'd0);
        check_eq("rst_alu_b", alu_b, 64'd0);
        check_eq("rst_ctrl_flags", 64'({alu_ctrl, flag_gt, flag_lt, flag_eq}), 64'd0);
        rst_n = 1'b1;

        // Basic ALU ops, wrap-around subtract.
        preload(3'd1, 64'd5);
        preload(3'd2, 64'd3);
        run_instr(ADD, 3'd3, 3'd1, 3'd2, 6'd0, 1'b0, 1'b0);
        check_eq("add_5_3", regs_m[3], 64'd8);
        read_reg(3'd3);
        preload(3'd1, 64'd0);
        preload(3'd2, 64'd1);
        run_instr(SUB, 3'd4, 3'd1, 3'd2, 6'd0, 1'b0, 1'b0);
        read_reg(3'd4);

        // Shift boundaries.
        preload(3'd1, 64'd1);
        run_instr(SHL, 3'd5, 3'd1, 3'd0, 6'd63, 1'b0, 1'b0);
        read_reg(3'd5);
        run_instr(SHL, 3'd5, 3'd1, 3'd0, 6'd0, 1'b0, 1'b0);
        read_reg(3'd5);
        preload(3'd6, 64'h8000_0000_0000_0001);
        run_instr(SHR, 3'd6, 3'd6, 3'd0, 6'd1, 1'b0, 1'b0);
        read_reg(3'd6);

        // Compare, then flags must persist across an ADD and a NOP.
        preload(3'd1, 64'd7);
        preload(3'd2, 64'd9);
        run_instr(CMP, 3'd0, 3'd1, 3'd2, 6'd0, 1'b0, 1'b0);
        run_instr(ADD, 3'd3, 3'd1, 3'd2, 6'd0, 1'b0, 1'b0);
        run_instr(NOP, 3'd2, 3'd1, 3'd1, 6'd0, 1'b0, 1'b0);
        read_reg(3'd0);
        read_reg(3'd2);

        // Held valid: one accept per three cycles, first done two edges in.
        @(negedge clk);
        instr       = {ADD, 3'd6, 3'd1, 3'd2, 4'b0000};
        instr_valid = 1'b1;
        pulses      = 0;
        first_pulse = 0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (done_valid) begin
                pulses++;
                if (first_pulse == 0) first_pulse = e;
            end
        end
        instr_valid = 1'b0;
        regs_m[6] = regs_m[1] + regs_m[2];
        check_eq("held_valid_pulses", 64'(pulses), 64'd3);
        check_eq("held_valid_first", 64'(first_pulse), 64'd2);
        read_reg(3'd6);

        // Randomized traffic including preload collisions.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), rand_val());
            run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'($urandom_range(0, 4)),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end
        for (int r = 0; r < 8; r++) read_reg(3'(r));

        // Reset in the middle of a long shift aborts it.
        preload(3'd1, 64'd3);
        @(negedge clk);
        instr       = {SHL, 3'd7, 3'd1, 1'b0, 6'd40};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check_eq("shift_started", 64'(instr_ready), 64'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_done", 64'(done_valid), 64'd0);
        check_eq("abort_ctrl_flags", 64'({alu_ctrl, flag_gt, flag_lt, flag_eq}), 64'd0);
        for (int i = 0; i < 8; i++) regs_m[i] = '0;
        gt_m = 1'b0;
        lt_m = 1'b0;
        eq_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 64'(instr_ready), 64'd1);
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done_valid) pulses++;
        end
        check_eq("abort_no_done", 64'(pulses), 64'd0);
        read_reg(3'd7);
        read_reg(3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
